id_ex_reg: RTL and testbench
============================

Name: id_ex_reg

Overview:
- Pipeline register between the decode stage, which reads the general register file, and the execute stage.
- Latches instruction context and the two register-file read operands.
- Applies a writeback bypass for the same-cycle register-file write, which the file's read port does not yet reflect.
- While the register is held, refreshes its held operands from later writebacks.
- Supports stall (hold) and flush (bubble insertion).

Parameters:
- PC_RESET, 32'h00003000, E_PC value after reset.
- HOLD_CNT_W, 8, width of the saturating consecutive-hold counter.

Ports:
- clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- Stall  input  1  hold all E_* contents this cycle
- Flush  input  1  load a bubble; overrides Stall
- D_Valid  input  1  decode slot holds a real instruction
- D_PC  input  32  decode instruction address
- D_Instr  input  32  decode instruction word
- D_RsAddr  input  5  first source register address
- D_RtAddr  input  5  second source register address
- D_RsData  input  32  register-file ReadData1 for D_RsAddr
- D_RtData  input  32  register-file ReadData2 for D_RtAddr
- D_WriteAddr  input  5  destination register
- D_WriteEnable  input  1  instruction writes a register
- W_WriteEnable  input  1  same signal driving the register-file WriteEnable
- W_WriteAddress  input  5  same signal driving the register-file WriteAddress
- W_WriteData  input  32  same signal driving the register-file WriteData
- E_Valid  output  1  registered D_Valid
- E_PC  output  32  registered PC
- E_Instr  output  32  registered instruction word
- E_RsAddr  output  5  registered first source register address
- E_RtAddr  output  5  registered second source register address
- E_RsData  output  32  registered, bypassed first operand
- E_RtData  output  32  registered, bypassed second operand
- E_WriteAddr  output  5  registered destination register
- E_WriteEnable  output  1  normalized write enable
- E_HoldCount  output  HOLD_CNT_W  consecutive cycles held by Stall, saturating

Behaviour:
- All outputs are registered; there are no combinational input-to-output paths.
- Reset (asynchronous, immediate, mid-operation included):
  - E_PC = PC_RESET.
  - Every other output = 0.
- Per rising edge, priority is Reset > Flush > Stall > Load.
- Write-hit definition:
  - wb_hit(a) = W_WriteEnable && W_WriteAddress != 0 && W_WriteAddress == a.
- Load (no Flush, no Stall):
  - E_Valid, E_PC, E_Instr, E_RsAddr, E_RtAddr and E_WriteAddr take their D_* values.
  - E_RsData = 0 if D_RsAddr == 0; else W_WriteData if wb_hit(D_RsAddr); else D_RsData. E_RtData is identical using Rt.
  - E_WriteEnable = D_WriteEnable && D_Valid && (D_WriteAddr != 0).
  - E_HoldCount = 0.
- Flush (bubble):
  - E_PC = D_PC, kept for later exception attribution.
  - E_Valid, E_Instr, both address fields, both data fields, E_WriteAddr and E_WriteEnable = 0.
  - E_HoldCount = 0.
  - Flush together with Stall is a flush.
- Stall (hold):
  - All fields retain their values except the two operand fields.
  - Operand refresh: if wb_hit(E_RsAddr), E_RsData = W_WriteData; same for Rt.
  - Address 0 is never refreshed.
  - Rationale: any writeback occurring while the register is held belongs to an older instruction, so the held instruction must observe it.
  - E_HoldCount increments by 1 and saturates at all-ones; there is no wrap.
- Bubbles carry E_WriteEnable = 0, so downstream stages never write $0 or perform a write from an invalid slot.
- Both operands may hit the same writeback (Rs == Rt); both take W_WriteData.

Test Plan:
1. Assert Reset mid-cycle, no clock edge. E_PC must be 00003000 immediately and all other outputs 0. Deassert Reset, then load D_PC=00003004, D_Instr=8C410004, D_Valid=1. The next edge gives E_PC=00003004 and E_Valid=1.
2. Bypass. Set D_RsAddr=5, D_RsData=11111111, W_WriteEnable=1, W_WriteAddress=5, W_WriteData=ABCD0000, D_RtAddr=6, D_RtData=22222222. Required: E_RsData=ABCD0000 and E_RtData=22222222. Repeat with W_WriteAddress=0: E_RsData=11111111.
3. $0 handling. Set D_RsAddr=0, D_RsData=DEADBEEF, D_WriteAddr=0, D_WriteEnable=1. Required: E_RsData=0 and E_WriteEnable=0.
4. Stall with refresh. Load E_RtAddr=9 and E_RtData=1. Hold Stall for 3 cycles while D_* changes. In hold cycle 2, write reg 9 with 00000077. Required: E_RtData=00000077, all other fields unchanged, E_HoldCount=3. On the next load, E_HoldCount=0.
5. Flush with Stall both high, D_PC=00003010. Required: E_Valid=0, E_Instr=0, E_WriteEnable=0, E_PC=00003010, E_HoldCount=0.
6. Saturation. Hold Stall for 300 cycles. Required: E_HoldCount sticks at FF with no wrap.

Source files
------------

// File: rtl/id_ex_reg.sv
// -----------------------------------------------------------------------------
// id_ex_reg
//
// Decode-to-execute pipeline register. It captures the instruction context and
// the two general-register-file read operands produced in decode, and presents
// them to execute one cycle later. Every output comes straight from a flop, so
// there is no combinational path from any input to any output.
//
// Operand correctness:
//   * The register file's read port does not yet reflect a write happening in
//     the same cycle. On a load, a writeback that targets a source register is
//     forwarded into the captured operand instead of the stale read data.
//   * While the register is held by Stall, any writeback belongs to an older
//     instruction. The held operands are refreshed from it, so the held
//     instruction still sees up-to-date values when it is finally released.
//   * Register $0 always reads as zero and is never bypassed or refreshed.
//
// Slot semantics (one rule for the whole block):
//   E_Valid marks a real instruction in the execute slot. A bubble (reset or
//   flush) has E_Valid = 0 and E_WriteEnable = 0, and E_WriteEnable is only
//   ever 1 for a valid slot with a nonzero destination. Downstream stages can
//   therefore use E_WriteEnable directly without qualifying it.
//
// Update priority on each rising edge: Reset > Flush > Stall > Load.
//
// Ports:
//   clk             rising-edge clock
//   Reset           asynchronous, active-high reset
//   Stall           hold the slot this cycle (operands still refresh)
//   Flush           load a bubble; wins over Stall
//   D_Valid         decode slot holds a real instruction
//   D_PC            decode instruction address
//   D_Instr         decode instruction word
//   D_RsAddr        first source register address
//   D_RtAddr        second source register address
//   D_RsData        register-file read data for D_RsAddr
//   D_RtData        register-file read data for D_RtAddr
//   D_WriteAddr     destination register
//   D_WriteEnable   instruction writes a register
//   W_WriteEnable   register-file write enable (writeback stage)
//   W_WriteAddress  register-file write address (writeback stage)
//   W_WriteData     register-file write data (writeback stage)
//   E_Valid         registered slot-valid flag
//   E_PC            registered PC (kept on flush for exception attribution)
//   E_Instr         registered instruction word
//   E_RsAddr        registered first source address
//   E_RtAddr        registered second source address
//   E_RsData        registered, bypassed / refreshed first operand
//   E_RtData        registered, bypassed / refreshed second operand
//   E_WriteAddr     registered destination register
//   E_WriteEnable   normalized write enable
//   E_HoldCount     consecutive cycles held by Stall, saturating at all-ones
// -----------------------------------------------------------------------------
module id_ex_reg #(
    parameter logic [31:0] PC_RESET   = 32'h00003000,
    parameter int          HOLD_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  D_Valid,
    input  logic [31:0]           D_PC,
    input  logic [31:0]           D_Instr,
    input  logic [4:0]            D_RsAddr,
    input  logic [4:0]            D_RtAddr,
    input  logic [31:0]           D_RsData,
    input  logic [31:0]           D_RtData,
    input  logic [4:0]            D_WriteAddr,
    input  logic                  D_WriteEnable,
    input  logic                  W_WriteEnable,
    input  logic [4:0]            W_WriteAddress,
    input  logic [31:0]           W_WriteData,
    output logic                  E_Valid,
    output logic [31:0]           E_PC,
    output logic [31:0]           E_Instr,
    output logic [4:0]            E_RsAddr,
    output logic [4:0]            E_RtAddr,
    output logic [31:0]           E_RsData,
    output logic [31:0]           E_RtData,
    output logic [4:0]            E_WriteAddr,
    output logic                  E_WriteEnable,
    output logic [HOLD_CNT_W-1:0] E_HoldCount
);

    // ------------------------------------------------------------------
    // Writeback hit detection. A write to $0 never counts as a hit.
    // ------------------------------------------------------------------
    logic wbLive;
    logic loadRsHit;
    logic loadRtHit;
    logic heldRsHit;
    logic heldRtHit;

    assign wbLive    = W_WriteEnable && (W_WriteAddress != 5'd0);
    assign loadRsHit = wbLive && (W_WriteAddress == D_RsAddr);
    assign loadRtHit = wbLive && (W_WriteAddress == D_RtAddr);
    assign heldRsHit = wbLive && (W_WriteAddress == E_RsAddr);
    assign heldRtHit = wbLive && (W_WriteAddress == E_RtAddr);

    // ------------------------------------------------------------------
    // Operand values captured on a normal load.
    // $0 is forced to zero regardless of what the read port returns.
    // ------------------------------------------------------------------
    logic [31:0] loadRsData;
    logic [31:0] loadRtData;

    always_comb begin
        loadRsData = D_RsData;
        if (D_RsAddr == 5'd0) begin
            loadRsData = 32'd0;
        end else if (loadRsHit) begin
            loadRsData = W_WriteData;
        end
    end

    always_comb begin
        loadRtData = D_RtData;
        if (D_RtAddr == 5'd0) begin
            loadRtData = 32'd0;
        end else if (loadRtHit) begin
            loadRtData = W_WriteData;
        end
    end

    // ------------------------------------------------------------------
    // Operand values while held. Address $0 can never hit, so a held
    // zero operand stays zero.
    // ------------------------------------------------------------------
    logic [31:0] heldRsData;
    logic [31:0] heldRtData;

    assign heldRsData = heldRsHit ? W_WriteData : E_RsData;
    assign heldRtData = heldRtHit ? W_WriteData : E_RtData;

    // Write enable is normalized so bubbles and $0 destinations never write.
    logic loadWriteEnable;

    assign loadWriteEnable = D_WriteEnable && D_Valid && (D_WriteAddr != 5'd0);

    // Saturating hold counter: stops at all-ones rather than wrapping.
    logic [HOLD_CNT_W-1:0] holdCountNext;

    assign holdCountNext = (E_HoldCount == {HOLD_CNT_W{1'b1}})
                         ? E_HoldCount
                         : E_HoldCount + HOLD_CNT_W'(1);

    // ------------------------------------------------------------------
    // The pipeline register itself.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            E_Valid       <= 1'b0;
            E_PC          <= PC_RESET;
            E_Instr       <= 32'd0;
            E_RsAddr      <= 5'd0;
            E_RtAddr      <= 5'd0;
            E_RsData      <= 32'd0;
            E_RtData      <= 32'd0;
            E_WriteAddr   <= 5'd0;
            E_WriteEnable <= 1'b0;
            E_HoldCount   <= '0;
        end else if (Flush) begin
            // Bubble. The PC is still captured so a later exception can be
            // attributed to the squashed slot's address.
            E_Valid       <= 1'b0;
            E_PC          <= D_PC;
            E_Instr       <= 32'd0;
            E_RsAddr      <= 5'd0;
            E_RtAddr      <= 5'd0;
            E_RsData      <= 32'd0;
            E_RtData      <= 32'd0;
            E_WriteAddr   <= 5'd0;
            E_WriteEnable <= 1'b0;
            E_HoldCount   <= '0;
        end else if (Stall) begin
            // Context is frozen; only the operands track later writebacks.
            E_RsData      <= heldRsData;
            E_RtData      <= heldRtData;
            E_HoldCount   <= holdCountNext;
        end else begin
            E_Valid       <= D_Valid;
            E_PC          <= D_PC;
            E_Instr       <= D_Instr;
            E_RsAddr      <= D_RsAddr;
            E_RtAddr      <= D_RtAddr;
            E_RsData      <= loadRsData;
            E_RtData      <= loadRtData;
            E_WriteAddr   <= D_WriteAddr;
            E_WriteEnable <= loadWriteEnable;
            E_HoldCount   <= '0;
        end
    end

endmodule

// File: tb/tb_id_ex_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_reg
//
// Random phase: the bench keeps an architectural register file. Decode reads
// come from it (pre-write), and the expected execute-slot operand is simply
// the architectural value of the slot's source register after the current
// writeback, whether the slot was just loaded or is being held.
// Directed phase: the scenarios from the block's test plan with fixed values.
// -----------------------------------------------------------------------------
module tb_id_ex_reg;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic Reset;

    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        Stall, Flush;
    logic        D_Valid;
    logic [31:0] D_PC, D_Instr;
    logic [4:0]  D_RsAddr, D_RtAddr;
    logic [31:0] D_RsData, D_RtData;
    logic [4:0]  D_WriteAddr;
    logic        D_WriteEnable;
    logic        W_WriteEnable;
    logic [4:0]  W_WriteAddress;
    logic [31:0] W_WriteData;
    logic        E_Valid;
    logic [31:0] E_PC, E_Instr;
    logic [4:0]  E_RsAddr, E_RtAddr;
    logic [31:0] E_RsData, E_RtData;
    logic [4:0]  E_WriteAddr;
    logic        E_WriteEnable;
    logic [7:0]  E_HoldCount;

    id_ex_reg #(
        .PC_RESET  (32'h00003000),
        .HOLD_CNT_W(8)
    ) dut (
        .clk           (clk),
        .Reset         (Reset),
        .Stall         (Stall),
        .Flush         (Flush),
        .D_Valid       (D_Valid),
        .D_PC          (D_PC),
        .D_Instr       (D_Instr),
        .D_RsAddr      (D_RsAddr),
        .D_RtAddr      (D_RtAddr),
        .D_RsData      (D_RsData),
        .D_RtData      (D_RtData),
        .D_WriteAddr   (D_WriteAddr),
        .D_WriteEnable (D_WriteEnable),
        .W_WriteEnable (W_WriteEnable),
        .W_WriteAddress(W_WriteAddress),
        .W_WriteData   (W_WriteData),
        .E_Valid       (E_Valid),
        .E_PC          (E_PC),
        .E_Instr       (E_Instr),
        .E_RsAddr      (E_RsAddr),
        .E_RtAddr      (E_RtAddr),
        .E_RsData      (E_RsData),
        .E_RtData      (E_RtData),
        .E_WriteAddr   (E_WriteAddr),
        .E_WriteEnable (E_WriteEnable),
        .E_HoldCount   (E_HoldCount)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rs_addr;
        logic [4:0]  rt_addr;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [4:0]  wr_addr;
        logic        wr_en;
        logic [7:0]  hold;
    } slot_t;

    slot_t exp_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every clock edge presents a new slot; compare it against the
    // oldest expectation issued by the driver.
    always @(posedge clk) begin
        #1;
        if (!Reset && exp_q.size() > 0) begin
            slot_t e;
            e = exp_q.pop_front();
            check("sb_valid",  32'(E_Valid),       32'(e.valid));
            check("sb_pc",     E_PC,               e.pc);
            check("sb_instr",  E_Instr,            e.instr);
            check("sb_rsaddr", 32'(E_RsAddr),      32'(e.rs_addr));
            check("sb_rtaddr", 32'(E_RtAddr),      32'(e.rt_addr));
            check("sb_rsdata", E_RsData,           e.rs_data);
            check("sb_rtdata", E_RtData,           e.rt_data);
            check("sb_wraddr", 32'(E_WriteAddr),   32'(e.wr_addr));
            check("sb_wren",   32'(E_WriteEnable), 32'(e.wr_en));
            check("sb_hold",   32'(E_HoldCount),   32'(e.hold));
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] arch_rf[32];
    slot_t       model;

    function automatic slot_t reset_slot();
        slot_t s;
        s    = '0;
        s.pc = 32'h00003000;
        return s;
    endfunction

    // One random cycle: drive inputs, advance the architectural state, and
    // issue the expected execute slot.
    task automatic rand_cycle();
        int h;
        @(negedge clk);
        Stall          = ($urandom_range(0, 2) == 0);
        Flush          = ($urandom_range(0, 9) == 0);
        D_Valid        = ($urandom_range(0, 4) != 0);
        D_PC           = $urandom;
        D_Instr        = $urandom;
        D_RsAddr       = 5'($urandom_range(0, 7));
        D_RtAddr       = 5'($urandom_range(0, 7));
        D_WriteAddr    = 5'($urandom_range(0, 7));
        D_WriteEnable  = $urandom_range(0, 1) == 1;
        W_WriteEnable  = ($urandom_range(0, 2) != 0);
        W_WriteAddress = 5'($urandom_range(0, 7));
        W_WriteData    = $urandom;
        // The real file returns 0 for $0; drive junk there to prove it is ignored.
        D_RsData = (D_RsAddr == 5'd0) ? $urandom : arch_rf[D_RsAddr];
        D_RtData = (D_RtAddr == 5'd0) ? $urandom : arch_rf[D_RtAddr];

        // Architectural write happens at this edge.
        if (W_WriteEnable && W_WriteAddress != 5'd0) arch_rf[W_WriteAddress] = W_WriteData;

        if (Flush) begin
            model    = '0;
            model.pc = D_PC;
        end else if (Stall) begin
            h          = int'(model.hold) + 1;
            model.hold = (h > 255) ? 8'hFF : 8'(h);
        end else begin
            model.valid   = D_Valid;
            model.pc      = D_PC;
            model.instr   = D_Instr;
            model.rs_addr = D_RsAddr;
            model.rt_addr = D_RtAddr;
            model.wr_addr = D_WriteAddr;
            model.wr_en   = D_WriteEnable && D_Valid && (D_WriteAddr != 5'd0);
            model.hold    = 8'd0;
        end
        // A live slot always sees the current architectural value.
        model.rs_data = arch_rf[model.rs_addr];
        model.rt_data = arch_rf[model.rt_addr];
        exp_q.push_back(model);
    endtask

    // ---------------- directed driver helpers ----------------
    task automatic idle_inputs();
        Stall = 0; Flush = 0; D_Valid = 0; D_PC = 0; D_Instr = 0;
        D_RsAddr = 0; D_RtAddr = 0; D_RsData = 0; D_RtData = 0;
        D_WriteAddr = 0; D_WriteEnable = 0;
        W_WriteEnable = 0; W_WriteAddress = 0; W_WriteData = 0;
    endtask

    // Apply the currently driven inputs for one edge, then sample after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int wait_cycles;
        Reset = 1'b1;
        idle_inputs();
        for (int i = 0; i < 32; i++) arch_rf[i] = 32'd0;
        model = reset_slot();
        repeat (2) @(negedge clk);
        check("reset_pc", E_PC, 32'h00003000);
        check("reset_valid", 32'(E_Valid), 32'd0);
        Reset = 1'b0;

        // Random phase.
        repeat (600) rand_cycle();
        @(negedge clk);
        idle_inputs();
        Stall = 1'b1;   // keep the slot quiet while the last expectation drains
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 5) begin
            @(negedge clk);
            wait_cycles++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end

        // 1. Mid-cycle asynchronous reset, then first load.
        @(negedge clk);
        #2;
        Reset = 1'b1;
        #1;
        check("t1_rst_pc",    E_PC,                32'h00003000);
        check("t1_rst_valid", 32'(E_Valid),        32'd0);
        check("t1_rst_instr", E_Instr,             32'd0);
        check("t1_rst_rs",    E_RsData,            32'd0);
        check("t1_rst_rt",    E_RtData,            32'd0);
        check("t1_rst_wren",  32'(E_WriteEnable),  32'd0);
        check("t1_rst_hold",  32'(E_HoldCount),    32'd0);
        @(negedge clk);
        Reset = 1'b0;
        idle_inputs();
        D_PC = 32'h00003004; D_Instr = 32'h8C410004; D_Valid = 1;
        step();
        check("t1_pc",    E_PC,         32'h00003004);
        check("t1_valid", 32'(E_Valid), 32'd1);
        check("t1_instr", E_Instr,      32'h8C410004);

        // 2. Same-cycle writeback bypass.
        @(negedge clk);
        D_RsAddr = 5; D_RsData = 32'h11111111; D_RtAddr = 6; D_RtData = 32'h22222222;
        W_WriteEnable = 1; W_WriteAddress = 5; W_WriteData = 32'hABCD0000;
        step();
        check("t2_bypass_rs", E_RsData, 32'hABCD0000);
        check("t2_nobyp_rt",  E_RtData, 32'h22222222);
        @(negedge clk);
        W_WriteAddress = 0;
        step();
        check("t2_wb_zero_rs", E_RsData, 32'h11111111);

        // 3. $0 source and destination.
        @(negedge clk);
        W_WriteEnable = 0;
        D_RsAddr = 0; D_RsData = 32'hDEADBEEF; D_WriteAddr = 0; D_WriteEnable = 1;
        step();
        check("t3_rs_zero",   E_RsData,           32'd0);
        check("t3_wren_zero", 32'(E_WriteEnable), 32'd0);
        @(negedge clk);
        D_WriteAddr = 3;
        step();
        check("t3_wren_set", 32'(E_WriteEnable), 32'd1);
        @(negedge clk);
        D_Valid = 0;
        step();
        check("t3_wren_invalid", 32'(E_WriteEnable), 32'd0);

        // 4. Stall with operand refresh.
        @(negedge clk);
        idle_inputs();
        D_Valid = 1; D_PC = 32'h00003008; D_Instr = 32'h01095020;
        D_RsAddr = 4; D_RsData = 32'h00000044; D_RtAddr = 9; D_RtData = 32'h00000001;
        D_WriteAddr = 10; D_WriteEnable = 1;
        step();
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            Stall = 1;
            D_PC = 32'h00004000 + 32'(c); D_Instr = $urandom;
            D_RsAddr = 5'(c); D_RtAddr = 5'(c + 10); D_RsData = $urandom; D_RtData = $urandom;
            W_WriteEnable = (c == 2); W_WriteAddress = 9; W_WriteData = 32'h00000077;
            step();
        end
        check("t4_rt_refresh", E_RtData,           32'h00000077);
        check("t4_rs_held",    E_RsData,           32'h00000044);
        check("t4_pc_held",    E_PC,               32'h00003008);
        check("t4_instr_held", E_Instr,            32'h01095020);
        check("t4_rtaddr",     32'(E_RtAddr),      32'd9);
        check("t4_wraddr",     32'(E_WriteAddr),   32'd10);
        check("t4_wren",       32'(E_WriteEnable), 32'd1);
        check("t4_hold3",      32'(E_HoldCount),   32'd3);
        @(negedge clk);
        Stall = 0; W_WriteEnable = 1; W_WriteAddress = 7; W_WriteData = 32'h0BADF00D;
        D_RsAddr = 7; D_RtAddr = 7; D_RsData = 32'h1; D_RtData = 32'h2;
        step();
        check("t4_hold_clear", 32'(E_HoldCount), 32'd0);
        check("t4_same_rs",    E_RsData,         32'h0BADF00D);
        check("t4_same_rt",    E_RtData,         32'h0BADF00D);

        // 5. Flush beats Stall.
        @(negedge clk);
        W_WriteEnable = 0; Stall = 1;
        step();   // one held cycle so the counter is nonzero before the flush
        @(negedge clk);
        Flush = 1; D_PC = 32'h00003010; D_Valid = 1; D_Instr = 32'hFFFFFFFF;
        step();
        check("t5_valid", 32'(E_Valid),       32'd0);
        check("t5_instr", E_Instr,            32'd0);
        check("t5_wren",  32'(E_WriteEnable), 32'd0);
        check("t5_pc",    E_PC,               32'h00003010);
        check("t5_hold",  32'(E_HoldCount),   32'd0);
        check("t5_rs",    E_RsData,           32'd0);

        // 6. Hold counter saturation.
        @(negedge clk);
        Flush = 0; Stall = 1;
        for (int c = 1; c <= 300; c++) begin
            step();
            if (c == 254) check("t6_hold_254", 32'(E_HoldCount), 32'd254);
            if (c == 255) check("t6_hold_255", 32'(E_HoldCount), 32'd255);
        end
        check("t6_hold_300", 32'(E_HoldCount), 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Watchdog: the sequence above is bounded, this only guards against a hang.
    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
